// File: rtl/memory_arbiter_rr.sv
// rtl/memory_arbiter_rr.sv - N-channel round-robin/fixed-priority memory arbiter; optional bus locking under ARB_LOCK_EN
module memory_arbiter_rr #(
  parameter int NCH      = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     prio_mode,
  input  logic [NCH-1:0]           req_valid,
  input  logic [NCH-1:0]           req_wen,
  input  logic [NCH-1:0]           req_lock,
  input  logic [NCH*ADDR_W-1:0]    req_addr,
  input  logic [NCH*DATA_W-1:0]    req_wdata,
  output logic                     mem_ren,
  output logic                     mem_wen,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_store,
  input  logic [DATA_W-1:0]        mem_load,
  input  logic                     mem_ready,
  output logic [NCH-1:0]           grant,
  output logic [NCH-1:0]           rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NCH);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

`ifdef ARB_LOCK_EN
  localparam int LCW = $clog2(MAX_LOCK + 1);
  logic [LCW-1:0]      lock_cnt_q, lock_cnt_d;
`else
  logic                unused_lock;
  assign unused_lock = ^req_lock;
`endif

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand_idx;
  int                  cand;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_wen;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [NCH-1:0]      owner_oh;

  // Pick the next winner: lowest index in fixed mode, otherwise search from last+1 with wrap
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NCH; k++) begin
      cand     = prio_mode ? k : (int'(last_q) + 1 + k) % NCH;
      cand_idx = IDX_W'(cand);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Request mux: HOLD re-latches the current owner, IDLE latches the new winner
  always_comb begin
    sel_idx   = (state_q == HOLD) ? owner_q : win_idx;
    sel_wen   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (IDX_W'(i) == sel_idx) begin
        sel_wen   = req_wen[IDX_W'(i)];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic for the IDLE/BUSY/HOLD ownership FSM
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          owner_d = win_idx;
          last_d  = win_idx;
          wen_d   = sel_wen;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          state_d = BUSY;
`ifdef ARB_LOCK_EN
          lock_cnt_d = '0;
`endif
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d = IDLE;
`ifdef ARB_LOCK_EN
          // Budget check keeps one ownership to MAX_LOCK transactions in total
          if (req_lock[owner_q] && (lock_cnt_q < LCW'(MAX_LOCK - 1)))
            state_d = HOLD;
`endif
        end
      end
      HOLD: begin
        if (req_valid[owner_q]) begin
          wen_d   = sel_wen;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          state_d = BUSY;
`ifdef ARB_LOCK_EN
          lock_cnt_d = lock_cnt_q + LCW'(1);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any transaction in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NCH - 1);
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  // Output decode from the registered state; completion follows mem_ready directly
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    busy      = (state_q == BUSY);
    grant     = (state_q != IDLE) ? owner_oh : '0;
    mem_ren   = busy & ~wen_q;
    mem_wen   = busy & wen_q;
    mem_addr  = busy ? addr_q : '0;
    mem_store = busy ? wdata_q : '0;
    rsp_valid = (busy && mem_ready) ? owner_oh : '0;
    rsp_rdata = (busy && mem_ready && !wen_q) ? mem_load : '0;
  end

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// tb/tb_memory_arbiter_rr.sv - directed vector bench for memory_arbiter_rr
module tb_memory_arbiter_rr;

  logic        CLK;
  logic        RST;
  logic        prio_mode;
  logic [2:0]  req_valid, req_wen, req_lock;
  logic [95:0] req_addr, req_wdata;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_store, mem_load;
  logic        mem_ready;
  logic [2:0]  grant, rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;

  int checks;
  int failures;

  localparam logic [31:0] C0 = 32'h0000_0040, C1 = 32'h0000_0100, C2 = 32'h0000_0200;
  localparam logic [31:0] D0 = 32'h1111_1111, D1 = 32'hDEAD_BEEF, D2 = 32'h2222_2222;

  memory_arbiter_rr #(.NCH(3), .ADDR_W(32), .DATA_W(32), .MAX_LOCK(4)) dut (
    .CLK(CLK), .RST(RST), .prio_mode(prio_mode),
    .req_valid(req_valid), .req_wen(req_wen), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_store(mem_store),
    .mem_load(mem_load), .mem_ready(mem_ready),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  rv;
    logic [2:0]  wen;
    logic        prio;
    logic        mr;
    logic [31:0] load;
    logic [2:0]  g;
    logic [2:0]  rsp;
    logic        b;
    logic        ren;
    logic        wn;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(logic [2:0] rv, logic [2:0] wen, logic prio, logic mr,
                              logic [31:0] load, logic [2:0] g, logic [2:0] rsp,
                              logic b, logic ren, logic wn,
                              logic [31:0] addr, logic [31:0] store, logic [31:0] rdata);
    vec_t v;
    v.rv = rv; v.wen = wen; v.prio = prio; v.mr = mr; v.load = load;
    v.g = g; v.rsp = rsp; v.b = b; v.ren = ren; v.wn = wn;
    v.addr = addr; v.store = store; v.rdata = rdata;
    return v;
  endfunction

  function automatic vec_t mk_idle(logic [2:0] rv, logic [2:0] wen, logic prio);
    return mk(rv, wen, prio, 1'b0, 32'h0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, compare, advance to the next falling edge
  task automatic apply(input vec_t v, input string tag);
    req_valid = v.rv;
    req_wen   = v.wen;
    prio_mode = v.prio;
    mem_ready = v.mr;
    mem_load  = v.load;
    #1;
    chk({tag, " grant"},     32'(grant),     32'(v.g));
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(v.rsp));
    chk({tag, " busy"},      32'(busy),      32'(v.b));
    chk({tag, " mem_ren"},   32'(mem_ren),   32'(v.ren));
    chk({tag, " mem_wen"},   32'(mem_wen),   32'(v.wn));
    chk({tag, " rsp_rdata"}, rsp_rdata,      v.rdata);
    if (v.b) begin
      chk({tag, " mem_addr"},  mem_addr,  v.addr);
      chk({tag, " mem_store"}, mem_store, v.store);
    end
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] lg [14];
    logic       lb [14];
    vec_t       v;
    logic [2:0] rvl;
    logic [31:0] ld;

    checks = 0;
    failures = 0;
    RST = 1'b1;
    prio_mode = 1'b0;
    req_valid = 3'b111;
    req_wen = 3'b000;
    req_lock = 3'b000;
    req_addr = {C2, C1, C0};
    req_wdata = {D2, D1, D0};
    mem_load = 32'h1234_5678;
    mem_ready = 1'b1;

    // Reset state with requests and mem_ready active
    @(negedge CLK);
    #1;
    chk("reset grant", 32'(grant), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset mem_ren", 32'(mem_ren), 32'h0);
    chk("reset mem_wen", 32'(mem_wen), 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    vecs[0]  = mk_idle(3'b111, 3'b000, 1'b0);
    vecs[1]  = mk(3'b111, 3'b000, 1'b0, 1'b1, 32'hA000_0001, 3'b001, 3'b001, 1'b1, 1'b1, 1'b0, C0, D0, 32'hA000_0001);
    vecs[2]  = mk_idle(3'b111, 3'b000, 1'b0);
    vecs[3]  = mk(3'b111, 3'b000, 1'b0, 1'b0, 32'hA000_0003, 3'b010, 3'b000, 1'b1, 1'b1, 1'b0, C1, D1, 32'h0);
    vecs[4]  = mk(3'b111, 3'b000, 1'b0, 1'b1, 32'hA000_0004, 3'b010, 3'b010, 1'b1, 1'b1, 1'b0, C1, D1, 32'hA000_0004);
    vecs[5]  = mk_idle(3'b111, 3'b000, 1'b0);
    vecs[6]  = mk(3'b111, 3'b000, 1'b0, 1'b1, 32'hA000_0006, 3'b100, 3'b100, 1'b1, 1'b1, 1'b0, C2, D2, 32'hA000_0006);
    vecs[7]  = mk_idle(3'b111, 3'b000, 1'b0);
    vecs[8]  = mk(3'b111, 3'b000, 1'b0, 1'b1, 32'hA000_0008, 3'b001, 3'b001, 1'b1, 1'b1, 1'b0, C0, D0, 32'hA000_0008);
    vecs[9]  = mk_idle(3'b101, 3'b000, 1'b1);
    vecs[10] = mk(3'b101, 3'b000, 1'b1, 1'b1, 32'hA000_000A, 3'b001, 3'b001, 1'b1, 1'b1, 1'b0, C0, D0, 32'hA000_000A);
    vecs[11] = mk_idle(3'b101, 3'b000, 1'b1);
    vecs[12] = mk(3'b101, 3'b000, 1'b1, 1'b1, 32'hA000_000C, 3'b001, 3'b001, 1'b1, 1'b1, 1'b0, C0, D0, 32'hA000_000C);
    vecs[13] = mk_idle(3'b100, 3'b000, 1'b1);
    vecs[14] = mk(3'b100, 3'b000, 1'b1, 1'b1, 32'hA000_000E, 3'b100, 3'b100, 1'b1, 1'b1, 1'b0, C2, D2, 32'hA000_000E);
    vecs[15] = mk_idle(3'b010, 3'b010, 1'b0);
    vecs[16] = mk(3'b010, 3'b010, 1'b0, 1'b1, 32'h5555_5555, 3'b010, 3'b010, 1'b1, 1'b0, 1'b1, C1, D1, 32'h0);
    vecs[17] = mk_idle(3'b000, 3'b000, 1'b0);

    for (int i = 0; i < 18; i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Long memory stall on channel 2; a mid-transaction address change must not leak through
    req_valid = 3'b100;
    req_wen = 3'b000;
    mem_ready = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) req_addr[64 +: 32] = 32'h0000_0999;
      #1;
      chk($sformatf("stall%0d mem_ren", i), 32'(mem_ren), 32'h1);
      chk($sformatf("stall%0d mem_addr", i), mem_addr, C2);
      chk($sformatf("stall%0d rsp_valid", i), 32'(rsp_valid), 32'h0);
      chk($sformatf("stall%0d grant", i), 32'(grant), 32'h4);
      @(negedge CLK);
    end
    mem_ready = 1'b1;
    mem_load = 32'h0000_7777;
    #1;
    chk("stall_end rsp_valid", 32'(rsp_valid), 32'h4);
    chk("stall_end rsp_rdata", rsp_rdata, 32'h0000_7777);
    @(negedge CLK);
    req_valid = 3'b000;
    mem_ready = 1'b0;
    req_addr = {C2, C1, C0};
    @(negedge CLK);

    // Reset while BUSY, then channel 0 must win against everyone
    req_valid = 3'b010;
    @(negedge CLK);
    #1;
    chk("prerst busy", 32'(busy), 32'h1);
    chk("prerst grant", 32'(grant), 32'h2);
    RST = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("rst grant", 32'(grant), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst mem_ren", 32'(mem_ren), 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
    mem_ready = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    req_valid = 3'b111;
    @(negedge CLK);
    #1;
    chk("postrst grant", 32'(grant), 32'h1);
    mem_ready = 1'b1;
    @(negedge CLK);
    req_valid = 3'b000;
    mem_ready = 1'b0;
    @(negedge CLK);

    // Channel 1 asks to lock with channel 0 waiting; mem_ready held high
`ifdef ARB_LOCK_EN
    lg = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010,
           3'b000, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000};
`else
    lg = '{3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b001,
           3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b000};
`endif
    lb = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    req_lock = 3'b010;
    for (int i = 0; i < 14; i++) begin
      rvl = (i == 0) ? 3'b010 : ((i < 12) ? 3'b011 : 3'b000);
      ld = 32'hB000_0000 + 32'(i);
      v = mk(rvl, 3'b000, 1'b0, 1'b1, ld, lg[i], lb[i] ? lg[i] : 3'b000,
             lb[i], lb[i], 1'b0,
             (lg[i] == 3'b010) ? C1 : C0, (lg[i] == 3'b010) ? D1 : D0,
             lb[i] ? ld : 32'h0);
      apply(v, $sformatf("lock%0d", i));
    end
    req_lock = 3'b000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
